// File: rtl/lsu.sv
// Load/store unit: one outstanding data-memory access with lane steering and load extension.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses skip memory and flag misalign_o.
module lsu #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              memren_i,
    input  logic              memwren_i,
    input  logic [2:0]        funct3_i,
    input  logic [DWIDTH-1:0] addr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [3:0]        dmem_be_o,
    output logic [DWIDTH-1:0] dmem_addr_o,
    output logic [DWIDTH-1:0] dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [DWIDTH-1:0] dmem_rdata_i,
    output logic              resp_valid_o,
    output logic [DWIDTH-1:0] resp_data_o,
    output logic              misalign_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [DWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic              misalign_q, misalign_d;

    logic              accept;
    logic              misaligned;
    logic [3:0]        store_be;
    logic [DWIDTH-1:0] store_data;
    logic [DWIDTH-1:0] load_data;
    logic [DWIDTH-1:0] byte_shift;
    logic [DWIDTH-1:0] half_shift;

    assign req_ready_o = (state_q == IDLE) && !reset;
    assign accept      = req_valid_i && req_ready_o && (memren_i ^ memwren_i);

    always_comb begin
        store_be   = 4'b1111;
        store_data = wdata_i;
        case (funct3_i)
            3'b000, 3'b100: begin
                store_be   = 4'b0001 << addr_i[1:0];
                store_data = {(DWIDTH/8){wdata_i[7:0]}};
            end
            3'b001, 3'b101: begin
                store_be   = 4'b0011 << {addr_i[1], 1'b0};
                store_data = {(DWIDTH/16){wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        case (funct3_i)
            3'b000, 3'b100: misaligned = 1'b0;
            3'b001, 3'b101: misaligned = addr_i[0];
            default:        misaligned = |addr_i[1:0];
        endcase
`endif
    end

    // Halfword lane uses addr[1] only, so an untrapped odd halfword reads its aligned half.
    always_comb begin
        byte_shift = dmem_rdata_i >> {addr_q[1:0], 3'b000};
        half_shift = dmem_rdata_i >> {addr_q[1], 4'b0000};
        case (funct3_q)
            3'b000:  load_data = {{(DWIDTH-8){byte_shift[7]}}, byte_shift[7:0]};
            3'b001:  load_data = {{(DWIDTH-16){half_shift[15]}}, half_shift[15:0]};
            3'b100:  load_data = {{(DWIDTH-8){1'b0}}, byte_shift[7:0]};
            3'b101:  load_data = {{(DWIDTH-16){1'b0}}, half_shift[15:0]};
            default: load_data = dmem_rdata_i;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        be_d       = be_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        misalign_d = misalign_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d       = memwren_i;
                    be_d       = store_be;
                    funct3_d   = funct3_i;
                    addr_d     = addr_i;
                    wdata_d    = memwren_i ? store_data : '0;
                    rdata_d    = '0;
                    misalign_d = misaligned;
                    state_d    = misaligned ? RESP : REQ;
                end
            end
            REQ: begin
                if (dmem_gnt_i) begin
                    state_d = we_q ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (dmem_rvalid_i) begin
                    rdata_d = load_data;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            be_q       <= 4'b0000;
            funct3_q   <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            be_q       <= be_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
        end
    end

    // Request and response buses read as zero outside the state that owns them.
    assign dmem_req_o   = (state_q == REQ);
    assign dmem_we_o    = dmem_req_o && we_q;
    assign dmem_be_o    = dmem_req_o ? be_q : 4'b0000;
    assign dmem_addr_o  = dmem_req_o ? {addr_q[DWIDTH-1:2], 2'b00} : '0;
    assign dmem_wdata_o = dmem_req_o ? wdata_q : '0;
    assign resp_valid_o = (state_q == RESP);
    assign resp_data_o  = resp_valid_o ? rdata_q : '0;
    assign misalign_o   = resp_valid_o && misalign_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: drives loads/stores against a cycle-scripted memory and
// compares responses against a scoreboard filled from an independent reference model.
module tb_lsu;

    logic        clk;
    logic        reset;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        memren_i;
    logic        memwren_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        resp_valid_o;
    logic [31:0] resp_data_o;
    logic        misalign_o;

    typedef struct packed {
        logic [31:0] data;
        logic        mis;
    } resp_t;

    resp_t sbQ[$];
    int    checkCount = 0;
    int    errCount   = 0;

    lsu #(.DWIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .memren_i     (memren_i),
        .memwren_i    (memwren_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_gnt_i   (dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i (dmem_rdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_data_o  (resp_data_o),
        .misalign_o   (misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, act, exp);
        end
    endtask

    // Reference model of the lane steering, written byte-by-byte.
    function automatic logic [3:0] modelBe(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000, 3'b100: modelBe = (off == 2'd0) ? 4'b0001 : (off == 2'd1) ? 4'b0010 :
                                      (off == 2'd2) ? 4'b0100 : 4'b1000;
            3'b001, 3'b101: modelBe = off[1] ? 4'b1100 : 4'b0011;
            default:        modelBe = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] w);
        case (f3)
            3'b000, 3'b100: modelWdata = {w[7:0], w[7:0], w[7:0], w[7:0]};
            3'b001, 3'b101: modelWdata = {w[15:0], w[15:0]};
            default:        modelWdata = w;
        endcase
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        int          o;
        o = int'(off);
        b = rd[o*8 +: 8];
        h = off[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  modelLoad = {{24{b[7]}}, b};
            3'b001:  modelLoad = {{16{h[15]}}, h};
            3'b100:  modelLoad = {24'h0, b};
            3'b101:  modelLoad = {16'h0, h};
            default: modelLoad = rd;
        endcase
    endfunction

    function automatic bit modelTrap(input logic [2:0] f3, input logic [1:0] off);
        bit trapOn;
`ifdef LSU_MISALIGN_TRAP_EN
        trapOn = 1'b1;
`else
        trapOn = 1'b0;
`endif
        if (f3 == 3'b000 || f3 == 3'b100) modelTrap = 1'b0;
        else if (f3 == 3'b001 || f3 == 3'b101) modelTrap = trapOn && off[0];
        else modelTrap = trapOn && (off != 2'b00);
    endfunction

    // Every response the DUT produces is matched against the oldest scoreboard entry.
    always @(negedge clk) begin
        if (resp_valid_o) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpResp", 32'd1, 32'd0);
            end else begin
                resp_t e;
                e = sbQ.pop_front();
                checkOutput("respData", resp_data_o, e.data);
                checkOutput("respMis", {31'd0, misalign_o}, {31'd0, e.mis});
            end
        end
    end

    // Called just after a rising edge; returns just after a rising edge.
    task automatic applyStimulus(input bit isLoad, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input int gntDly, input int rvDly);
        bit          trap;
        resp_t       e;
        logic [3:0]  expBe;
        logic [31:0] expAddr;
        logic [31:0] expWdata;
        trap     = modelTrap(f3, addr[1:0]);
        expBe    = modelBe(f3, addr[1:0]);
        expAddr  = {addr[31:2], 2'b00};
        expWdata = modelWdata(f3, wdata);
        e.mis    = trap;
        e.data   = (isLoad && !trap) ? modelLoad(f3, addr[1:0], rdata) : 32'h0;
        sbQ.push_back(e);

        req_valid_i = 1'b1;
        memren_i    = isLoad;
        memwren_i   = !isLoad;
        funct3_i    = f3;
        addr_i      = addr;
        wdata_i     = wdata;
        @(negedge clk);
        checkOutput("ready", {31'd0, req_ready_o}, 32'd1);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        memren_i    = 1'b0;
        memwren_i   = 1'b0;
        funct3_i    = 3'($urandom);
        addr_i      = $urandom;
        wdata_i     = $urandom;

        if (!trap) begin
            for (int i = 0; i < gntDly; i++) begin
                @(negedge clk);
                checkOutput("heldReq", {31'd0, dmem_req_o}, 32'd1);
                checkOutput("heldAddr", dmem_addr_o, expAddr);
                checkOutput("heldWe", {31'd0, dmem_we_o}, {31'd0, !isLoad});
                checkOutput("busyReady", {31'd0, req_ready_o}, 32'd0);
                @(posedge clk); #1;
            end
            dmem_gnt_i = 1'b1;
            if (isLoad) begin
                dmem_rvalid_i = 1'b1;
                dmem_rdata_i  = ~rdata;
            end
            @(negedge clk);
            checkOutput("gntReq", {31'd0, dmem_req_o}, 32'd1);
            checkOutput("gntAddr", dmem_addr_o, expAddr);
            checkOutput("gntWe", {31'd0, dmem_we_o}, {31'd0, !isLoad});
            if (!isLoad) begin
                checkOutput("gntBe", {28'd0, dmem_be_o}, {28'd0, expBe});
                checkOutput("gntWdata", dmem_wdata_o, expWdata);
            end
            @(posedge clk); #1;
            dmem_gnt_i    = 1'b0;
            dmem_rvalid_i = 1'b0;
            if (isLoad) begin
                for (int i = 1; i < rvDly; i++) begin
                    @(negedge clk);
                    checkOutput("waitNoReq", {31'd0, dmem_req_o}, 32'd0);
                    @(posedge clk); #1;
                end
                dmem_rvalid_i = 1'b1;
                dmem_rdata_i  = rdata;
                @(posedge clk); #1;
                dmem_rvalid_i = 1'b0;
                dmem_rdata_i  = $urandom;
            end
        end

        @(negedge clk);
        checkOutput("respPulse", {31'd0, resp_valid_o}, 32'd1);
        if (trap) checkOutput("trapNoReq", {31'd0, dmem_req_o}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("respEnd", {31'd0, resp_valid_o}, 32'd0);
        checkOutput("idleReady", {31'd0, req_ready_o}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout actual=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        reset         = 1'b1;
        req_valid_i   = 1'b0;
        memren_i      = 1'b0;
        memwren_i     = 1'b0;
        funct3_i      = 3'b000;
        addr_i        = 32'h0;
        wdata_i       = 32'h0;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("rstReady", {31'd0, req_ready_o}, 32'd0);
        checkOutput("rstReq", {31'd0, dmem_req_o}, 32'd0);
        checkOutput("rstWe", {31'd0, dmem_we_o}, 32'd0);
        checkOutput("rstBe", {28'd0, dmem_be_o}, 32'd0);
        checkOutput("rstAddr", dmem_addr_o, 32'd0);
        checkOutput("rstWdata", dmem_wdata_o, 32'd0);
        checkOutput("rstResp", {31'd0, resp_valid_o}, 32'd0);
        checkOutput("rstData", resp_data_o, 32'd0);
        checkOutput("rstMis", {31'd0, misalign_o}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        applyStimulus(1'b0, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 0, 1);
        applyStimulus(1'b0, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0, 0, 1);
        applyStimulus(1'b0, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 32'h0, 1, 1);
        applyStimulus(1'b0, 3'b111, 32'h0000_0408, 32'h0BAD_F00D, 32'h0, 0, 1);
        applyStimulus(1'b1, 3'b000, 32'h0000_0202, 32'h0, 32'h0080_0000, 0, 1);
        applyStimulus(1'b1, 3'b100, 32'h0000_0202, 32'h0, 32'h0080_0000, 0, 1);
        applyStimulus(1'b1, 3'b101, 32'h0000_0202, 32'h0, 32'h8001_0000, 0, 1);
        applyStimulus(1'b1, 3'b001, 32'h0000_0200, 32'h0, 32'h0000_F00F, 0, 1);
        applyStimulus(1'b1, 3'b000, 32'h0000_0201, 32'h0, 32'h1122_7F44, 1, 1);
        applyStimulus(1'b1, 3'b010, 32'h0000_010C, 32'h0, 32'h1234_5678, 3, 2);
        applyStimulus(1'b1, 3'b011, 32'h0000_0400, 32'h0, 32'hCAFE_BABE, 0, 1);
        applyStimulus(1'b1, 3'b001, 32'h0000_0301, 32'h0, 32'hAABB_CCDD, 0, 1);
        applyStimulus(1'b0, 3'b010, 32'h0000_0106, 32'h5555_AAAA, 32'h0, 0, 1);

        // Conflicting or absent enables must not start an access.
        req_valid_i = 1'b1;
        memren_i    = 1'b1;
        memwren_i   = 1'b1;
        @(posedge clk); #1;
        memren_i  = 1'b0;
        memwren_i = 1'b0;
        @(negedge clk);
        checkOutput("dropBothReq", {31'd0, dmem_req_o}, 32'd0);
        checkOutput("dropBothRdy", {31'd0, req_ready_o}, 32'd1);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(negedge clk);
        checkOutput("dropNoneReq", {31'd0, dmem_req_o}, 32'd0);
        @(posedge clk); #1;

        // Stray rvalid while idle is ignored.
        dmem_rvalid_i = 1'b1;
        @(posedge clk); #1;
        dmem_rvalid_i = 1'b0;
        @(negedge clk);
        checkOutput("strayRv", {31'd0, resp_valid_o}, 32'd0);
        @(posedge clk); #1;

        // Reset while waiting for load data, then a late rvalid.
        req_valid_i = 1'b1;
        memren_i    = 1'b1;
        funct3_i    = 3'b010;
        addr_i      = 32'h0000_0500;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        memren_i    = 1'b0;
        dmem_gnt_i  = 1'b1;
        @(posedge clk); #1;
        dmem_gnt_i = 1'b0;
        @(negedge clk);
        checkOutput("abortWaitReq", {31'd0, dmem_req_o}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abortRstRdy", {31'd0, req_ready_o}, 32'd0);
        @(posedge clk); #1;
        reset         = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h7777_7777;
        @(negedge clk);
        checkOutput("abortRdy", {31'd0, req_ready_o}, 32'd1);
        checkOutput("abortNoResp", {31'd0, resp_valid_o}, 32'd0);
        @(posedge clk); #1;
        dmem_rvalid_i = 1'b0;
        @(negedge clk);
        checkOutput("abortNoResp2", {31'd0, resp_valid_o}, 32'd0);
        @(posedge clk); #1;

        // Back-to-back store after the aborted load still works.
        applyStimulus(1'b0, 3'b001, 32'h0000_0600, 32'h0000_C3C3, 32'h0, 0, 1);

        checkOutput("sbEmpty", sbQ.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
